// File: rtl/vec_lane_sequencer.sv
// Vector lane sequencer: accepts one vector ALU request, runs NB_LANES SEW-wide
// elements per cycle under mask/tail-undisturbed policy and returns the assembled result.
module vec_lane_sequencer #(
    parameter int VLEN     = 128,
    parameter int NB_LANES = 4,
    parameter int ELEN     = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [5:0]      opcode,
    input  logic [2:0]      op_type,
    input  logic [2:0]      vsew,
    input  logic [10:0]     vl,
    input  logic            vm,
    input  logic [VLEN-1:0] v0,
    input  logic [VLEN-1:0] vs1,
    input  logic [63:0]     rs1,
    input  logic [4:0]      imm5,
    input  logic [VLEN-1:0] vs2,
    input  logic [VLEN-1:0] vd_old,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [VLEN-1:0] vd,
    output logic            illegal,
    output logic            busy
);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // RUN    | NB_LANES elements processed per cycle
    // RESP   | result held on vd until resp_ready

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_e;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b001001;
    localparam logic [5:0] OP_OR   = 6'b001010;
    localparam logic [5:0] OP_XOR  = 6'b001011;
    localparam logic [5:0] OP_MINU = 6'b000100;
    localparam logic [5:0] OP_MAXU = 6'b000110;
    localparam logic       NO_E64  = (ELEN < 64);

    state_e          state_q;
    logic            req_ready_q, resp_valid_q, illegal_q, busy_q;
    logic [VLEN-1:0] vd_q, vd_d;
    logic [11:0]     cnt_q, cnt_d;
    logic            run_last_d;

    logic [5:0]      opc_q;
    logic [2:0]      typ_q;
    logic [1:0]      sew_q;
    logic [11:0]     vl_q;
    logic            vm_q;
    logic [VLEN-1:0] v0_q, vs1_q, vs2_q;
    logic [63:0]     rs1_q;
    logic [4:0]      imm_q;

    logic            sew_bad, type_bad, opc_bad, req_ill;
    logic [11:0]     vlmax_in, vl_eff_in;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign illegal    = illegal_q;
    assign busy       = busy_q;
    assign vd         = vd_q;

    always_comb begin
        opc_bad = 1'b1;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MINU, OP_MAXU: opc_bad = 1'b0;
            default: opc_bad = 1'b1;
        endcase
    end

    assign sew_bad   = vsew[2] | (NO_E64 & (vsew[1:0] == 2'd3));
    assign type_bad  = !((op_type == 3'b001) || (op_type == 3'b010) || (op_type == 3'b100));
    assign req_ill   = sew_bad | type_bad | opc_bad;
    assign vlmax_in  = 12'(VLEN >> (3 + int'(vsew[1:0])));
    assign vl_eff_in = ({1'b0, vl} < vlmax_in) ? {1'b0, vl} : vlmax_in;

    function automatic logic [63:0] sew_mask(input logic [1:0] s);
        case (s)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] get_elem(input logic [VLEN-1:0] v, input int e,
                                             input logic [1:0] s);
        case (s)
            2'd0:    return 64'(v[e*8  +: 8]);
            2'd1:    return 64'(v[e*16 +: 16]);
            2'd2:    return 64'(v[e*32 +: 32]);
            default: return v[e*64 +: 64];
        endcase
    endfunction

    // Operands arrive zero-extended and masked to SEW, so the 64-bit compare is
    // an unsigned SEW compare and add/sub wrap once the result is re-masked.
    function automatic logic [63:0] alu(input logic [5:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_MINU: return (a < b) ? a : b;
            OP_MAXU: return (a > b) ? a : b;
            default: return a;
        endcase
    endfunction

    function automatic logic [63:0] op1_elem(input int e);
        logic [63:0] m;
        m = sew_mask(sew_q);
        case (typ_q)
            3'b001:  return get_elem(vs1_q, e, sew_q);
            3'b010:  return rs1_q & m;
            default: return {{59{imm_q[4]}}, imm_q} & m;
        endcase
    endfunction

    always_comb begin
        vd_d = vd_q;
        for (int j = 0; j < NB_LANES; j++) begin
            int          e;
            logic [63:0] y;
            e = int'(cnt_q) + j;
            y = '0;
            if ((e < int'(vl_q)) && (vm_q || v0_q[e])) begin
                y = alu(opc_q, get_elem(vs2_q, e, sew_q), op1_elem(e)) & sew_mask(sew_q);
                case (sew_q)
                    2'd0:    vd_d[e*8  +: 8]  = y[7:0];
                    2'd1:    vd_d[e*16 +: 16] = y[15:0];
                    2'd2:    vd_d[e*32 +: 32] = y[31:0];
                    default: vd_d[e*64 +: 64] = y;
                endcase
            end
        end
    end

    assign cnt_d      = cnt_q + 12'(NB_LANES);
    assign run_last_d = (cnt_d >= vl_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            busy_q       <= 1'b0;
            vd_q         <= '0;
            cnt_q        <= '0;
            opc_q        <= '0;
            typ_q        <= '0;
            sew_q        <= '0;
            vl_q         <= '0;
            vm_q         <= 1'b0;
            v0_q         <= '0;
            vs1_q        <= '0;
            vs2_q        <= '0;
            rs1_q        <= '0;
            imm_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        opc_q       <= opcode;
                        typ_q       <= op_type;
                        sew_q       <= vsew[1:0];
                        vl_q        <= vl_eff_in;
                        vm_q        <= vm;
                        v0_q        <= v0;
                        vs1_q       <= vs1;
                        vs2_q       <= vs2;
                        rs1_q       <= rs1;
                        imm_q       <= imm5;
                        vd_q        <= vd_old;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_ill) begin
                            illegal_q    <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (vl_eff_in == '0) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    vd_q  <= vd_d;
                    cnt_q <= cnt_d;
                    if (run_last_d) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        illegal_q    <= 1'b0;
                        busy_q       <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
